spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, SCLK half-period in clk cycles; legal range 2..255.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately.
REQ-004 start  in  1  frame request; sampled only while busy=0.
REQ-005 tx_data  in  8  byte to transmit; captured in the cycle start is accepted.
REQ-006 rx_data  out  8  last received byte; updated only at frame end.
REQ-007 busy  out  1  frame in progress, including the post-frame gap.
REQ-008 done  out  1  one-cycle pulse at frame end; rx_data valid in the same cycle.
REQ-009 SCLK  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-010 MOSI  out  1  serial data out, MSB first.
REQ-011 MISO  in  1  serial data in, MSB first; treated as synchronous to clk.
REQ-012 SS  out  1  slave select, active-low.

Function
REQ-013 FSM states: IDLE, SETUP, XFER, HOLD, GAP; a single divider counter times every state.
REQ-014 IDLE: SS=1, SCLK=0, busy=0; on start=1 at a clk edge, latch tx_data into tx shift register, load counter, enter SETUP.
REQ-015 SETUP: SS=0, SCLK=0, MOSI=tx_shift[7], busy=1; lasts exactly CLK_DIV cycles, then enter XFER.
REQ-016 XFER: SCLK toggles every CLK_DIV cycles, starting with a rising edge; exactly 8 rising and 8 falling edges per frame.
REQ-017 On the clk edge that drives SCLK 0->1: shift MISO into rx_shift[0] (rx_shift shifts left).
REQ-018 On the clk edge that drives SCLK 1->0: shift tx_shift left so MOSI presents the next bit; after the 8th falling edge, enter HOLD.
REQ-019 Bit counter is 3 bits and wraps 7->0 on the 8th bit; wrap triggers the XFER->HOLD transition.
REQ-020 HOLD: SS=0, SCLK=0, MOSI holds its last value; lasts CLK_DIV cycles; then enter GAP.
REQ-021 HOLD->GAP transition edge: SS goes 1, rx_data<=rx_shift, done=1 for that one cycle.
REQ-022 Total SS-low time is exactly 18*CLK_DIV clk cycles.
REQ-023 GAP: SS=1, SCLK=0, busy=1; lasts CLK_DIV cycles; then enter IDLE with busy=0.
REQ-024 start while busy=1 is ignored, not queued; tx_data changes while busy do not affect the frame in progress.
REQ-025 start held high continuously: a new frame is accepted on the first edge after IDLE is re-entered.
REQ-026 SCLK, SS, MOSI are registered outputs and glitch-free.

Reset
REQ-027 Reset values: SCLK=0, SS=1, MOSI=0, busy=0, done=0, rx_data=8'h00, FSM=IDLE, all counters and shift registers 0.
REQ-028 Reset mid-frame aborts immediately: SS=1, no done pulse, rx_data keeps its reset value 8'h00.
REQ-029 After reset deasserts, the first accepted start produces a complete, normal frame.

Verification
REQ-030 Loopback MOSI->MISO, CLK_DIV=4, tx_data=8'hA5 -> MOSI bits 1,0,1,0,0,1,0,1; done pulses once; rx_data=8'hA5.
REQ-031 MISO tied 1, tx_data=8'h00 -> rx_data=8'hFF; MISO tied 0 -> rx_data=8'h00.
REQ-032 Timing check, CLK_DIV=4 -> SS low 72 cycles; 8 SCLK rising edges; first rise 4 cycles after SS falls; busy clears 4 cycles after done.
REQ-033 Second start pulse mid-frame with different tx_data -> ignored; exactly one frame; original byte transmitted.
REQ-034 reset=0 after the 3rd SCLK rise -> SS=1, SCLK=0 asynchronously; no done; next start yields a full correct frame.
REQ-035 Slave model returning 8'hFF, 8'hFE, 8'hFD over 3 back-to-back frames with start held high -> rx_data sequence FF, FE, FD; SS high for exactly CLK_DIV+1 cycles between frames.

Source files
------------

// File: rtl/spi_master_if.sv
// SPI master bundle: host request/response and serial pins.
// master is the spi_master side; slave is the host/pin side.
interface spi_master_if;
   logic       start;
   logic [7:0] tx_data;
   logic [7:0] rx_data;
   logic       busy;
   logic       done;
   logic       SCLK;
   logic       MOSI;
   logic       MISO;
   logic       SS;

   modport master (
      input  start, tx_data, MISO,
      output rx_data, busy, done, SCLK, MOSI, SS
   );

   modport slave (
      output start, tx_data, MISO,
      input  rx_data, busy, done, SCLK, MOSI, SS
   );
endinterface

// File: rtl/spi_master.sv
// Single-byte SPI mode-0 master, MSB first.
// One divider counter paces setup, 16 half-periods, hold and gap.
module spi_master #(
   parameter int CLK_DIV = 4
) (
   input logic          clk,
   input logic          reset,
   spi_master_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD,
      GAP
   } state_t;

   localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);

   state_t     state;
   logic [7:0] cnt;
   logic [2:0] bit_cnt;
   logic       tail;
   logic [7:0] tx_shift;
   logic [7:0] rx_shift;

   // Frame sequencer; every output is a flop so the pins never glitch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         bit_cnt     <= 3'd0;
         tail        <= 1'b0;
         tx_shift    <= 8'd0;
         rx_shift    <= 8'd0;
         bus.rx_data <= 8'd0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.SCLK    <= 1'b0;
         bus.MOSI    <= 1'b0;
         bus.SS      <= 1'b1;
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  tx_shift <= bus.tx_data;
                  rx_shift <= 8'd0;
                  bit_cnt  <= 3'd0;
                  tail     <= 1'b0;
                  bus.MOSI <= bus.tx_data[7];
                  bus.SS   <= 1'b0;
                  bus.busy <= 1'b1;
                  cnt      <= DIV_LD;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  cnt      <= DIV_LD;
                  bus.SCLK <= 1'b1;
                  rx_shift <= {rx_shift[6:0], bus.MISO};
                  state    <= XFER;
               end
            end
            XFER: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  cnt <= DIV_LD;
                  if (bus.SCLK) begin
                     bus.SCLK <= 1'b0;
                     tx_shift <= {tx_shift[6:0], 1'b0};
                     bus.MOSI <= tx_shift[6];
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) tail <= 1'b1;
                  end else if (tail) begin
                     // last low half-period is over
                     tail  <= 1'b0;
                     state <= HOLD;
                  end else begin
                     bus.SCLK <= 1'b1;
                     rx_shift <= {rx_shift[6:0], bus.MISO};
                  end
               end
            end
            HOLD: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  cnt         <= DIV_LD;
                  bus.SS      <= 1'b1;
                  bus.rx_data <= rx_shift;
                  bus.done    <= 1'b1;
                  state       <= GAP;
               end
            end
            GAP: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: frame-timeline model plus
// directed loopback, tied-line, abort and slave scenarios.
module tb_spi_master;

   localparam int D = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   spi_master_if bus ();

   spi_master #(.CLK_DIV(D)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // MISO source: 0 loopback, 1 tied high, 2 tied low, 3 slave
   int mode = 0;
   int base_m = 0;
   int base_s = 0;

   logic [7:0] tab [3] = '{8'hFF, 8'hFE, 8'hFD};

   function automatic logic [7:0] slave_byte(input int i);
      if (i >= 0 && i < 3) return tab[i];
      return 8'h00;
   endfunction

   // Mode-0 slave: MSB out when SS falls, next bit on SCLK fall.
   logic [7:0] sreg = 8'h00;
   logic s_ss = 1'b1;
   logic s_sclk = 1'b0;
   int sfall = 0;
   always @(bus.SS or bus.SCLK) begin
      if (s_ss === 1'b1 && bus.SS === 1'b0) begin
         sreg  <= slave_byte(sfall - base_s);
         sfall <= sfall + 1;
      end else if (s_sclk === 1'b1 && bus.SCLK === 1'b0
                   && bus.SS === 1'b0) begin
         sreg <= {sreg[6:0], 1'b0};
      end
      s_ss   <= bus.SS;
      s_sclk <= bus.SCLK;
   end

   assign bus.MISO = (mode == 0) ? bus.MOSI :
                     (mode == 1) ? 1'b1 :
                     (mode == 2) ? 1'b0 : sreg[7];

   // Model: k = cycles since the accepting edge, -1 when idle.
   int k = -1;
   int m_acc = 0;
   logic [7:0] m_tx = 8'h00;
   logic [7:0] m_rxe = 8'h00;
   logic [7:0] m_rxd = 8'h00;

   function automatic logic [7:0] exp_rx(input logic [7:0] tx);
      case (mode)
         0: return tx;
         1: return 8'hFF;
         2: return 8'h00;
         default: return slave_byte(m_acc - base_m);
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         k     <= -1;
         m_rxd <= 8'h00;
      end else if (k < 0) begin
         if (bus.start) begin
            k     <= 0;
            m_tx  <= bus.tx_data;
            m_rxe <= exp_rx(bus.tx_data);
            m_acc <= m_acc + 1;
         end
      end else begin
         if (k + 1 == 18 * D) m_rxd <= m_rxe;
         if (k + 1 == 19 * D) k <= -1;
         else k <= k + 1;
      end
   end

   // Monitor results
   int cyc = 0;
   int done_cnt = 0;
   int rise_cnt = 0;
   int first_rise = -1;
   int ss_fall = 0;
   int ss_rise = 0;
   int ss_low = 0;
   int done_cyc = 0;
   int busy_lag = 0;
   int have_rise = 0;
   logic [7:0] mosi_cap = 8'h00;
   int gap_log[$];
   logic [7:0] rx_log[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic wait_done(input string nm);
      int d0;
      int n;
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({nm, " done seen"}, 32'(done_cnt != d0), 1);
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (bus.busy && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({nm, " idle"}, bus.busy, 0);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.tx_data = b;
      @(negedge clk);
      bus.start = 1'b0;
      #1;
   endtask

   initial begin
      int dc;
      int n;
      bus.start = 1'b0;
      bus.tx_data = 8'h00;
      #1 reset = 1'b0;

      fork
         begin : cmp
            logic e_ss, e_sclk, e_mosi, e_busy, e_done;
            int h, bi;
            forever begin
               @(negedge clk);
               e_busy = (k >= 0);
               e_ss   = !(k >= 0 && k < 18 * D);
               e_done = (k == 18 * D);
               e_sclk = 1'b0;
               e_mosi = 1'b0;
               if (k >= 0 && k < D) begin
                  e_mosi = m_tx[7];
               end else if (k >= D && k < 17 * D) begin
                  h = (k - D) / D;
                  e_sclk = (h % 2 == 0);
                  bi = 7 - (h + 1) / 2;
                  if (bi >= 0) e_mosi = m_tx[bi];
               end
               chk("cyc SS", bus.SS, e_ss);
               chk("cyc SCLK", bus.SCLK, e_sclk);
               chk("cyc MOSI", bus.MOSI, e_mosi);
               chk("cyc busy", bus.busy, e_busy);
               chk("cyc done", bus.done, e_done);
               chk("cyc rx_data", bus.rx_data, m_rxd);
            end
         end
         begin : mon
            logic p_ss, p_sclk, p_busy;
            p_ss = 1'b1;
            p_sclk = 1'b0;
            p_busy = 1'b0;
            forever begin
               @(negedge clk);
               cyc++;
               if (p_ss && !bus.SS) begin
                  ss_fall = cyc;
                  rise_cnt = 0;
                  first_rise = -1;
                  mosi_cap = 8'h00;
                  if (have_rise != 0) gap_log.push_back(cyc - ss_rise);
               end
               if (!p_ss && bus.SS) begin
                  ss_rise = cyc;
                  ss_low = cyc - ss_fall;
                  have_rise = 1;
               end
               if (!p_sclk && bus.SCLK) begin
                  rise_cnt++;
                  mosi_cap = {mosi_cap[6:0], bus.MOSI};
                  if (rise_cnt == 1) first_rise = cyc - ss_fall;
               end
               if (bus.done) begin
                  done_cnt++;
                  done_cyc = cyc;
                  rx_log.push_back(bus.rx_data);
               end
               if (p_busy && !bus.busy) busy_lag = cyc - done_cyc;
               p_ss = bus.SS;
               p_sclk = bus.SCLK;
               p_busy = bus.busy;
            end
         end
      join_none

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst SS", bus.SS, 1);
      chk("rst SCLK", bus.SCLK, 0);
      chk("rst MOSI", bus.MOSI, 0);
      chk("rst busy", bus.busy, 0);
      chk("rst done", bus.done, 0);
      chk("rst rx_data", bus.rx_data, 8'h00);
      @(negedge clk);
      reset = 1'b1;

      // loopback A5 with timing
      mode = 0;
      dc = done_cnt;
      send(8'hA5);
      wait_done("A5");
      chk("A5 rx_data", bus.rx_data, 8'hA5);
      chk("A5 mosi bits", mosi_cap, 8'hA5);
      chk("A5 sclk rises", rise_cnt, 8);
      chk("A5 first rise", first_rise, 4);
      chk("A5 ss low", ss_low, 72);
      wait_idle("A5");
      chk("A5 busy lag", busy_lag, 4);
      chk("A5 done count", done_cnt - dc, 1);

      // tied MISO
      mode = 1;
      send(8'h00);
      wait_done("tie1");
      chk("tie1 rx_data", bus.rx_data, 8'hFF);
      wait_idle("tie1");
      mode = 2;
      send(8'h00);
      wait_done("tie0");
      chk("tie0 rx_data", bus.rx_data, 8'h00);
      wait_idle("tie0");

      // second start mid-frame ignored
      mode = 0;
      dc = done_cnt;
      send(8'h5A);
      repeat (20) @(negedge clk);
      bus.start = 1'b1;
      bus.tx_data = 8'h3C;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("ign");
      chk("ign rx_data", bus.rx_data, 8'h5A);
      chk("ign mosi bits", mosi_cap, 8'h5A);
      wait_idle("ign");
      repeat (100) @(negedge clk);
      #1;
      chk("ign done count", done_cnt - dc, 1);

      // abort after third SCLK rise
      send(8'hC3);
      n = 0;
      while (rise_cnt < 3 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("abort rise3", rise_cnt, 3);
      dc = done_cnt;
      #1 reset = 1'b0;
      #1;
      chk("abort SS", bus.SS, 1);
      chk("abort SCLK", bus.SCLK, 0);
      chk("abort busy", bus.busy, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (80) @(negedge clk);
      #1;
      chk("abort no done", done_cnt - dc, 0);
      chk("abort rx_data", bus.rx_data, 8'h00);
      send(8'h96);
      wait_done("post");
      chk("post rx_data", bus.rx_data, 8'h96);
      chk("post mosi bits", mosi_cap, 8'h96);
      chk("post ss low", ss_low, 72);
      wait_idle("post");

      // three back-to-back frames from the slave
      base_m = m_acc;
      base_s = sfall;
      mode = 3;
      rx_log.delete();
      gap_log.delete();
      dc = done_cnt;
      @(negedge clk);
      bus.tx_data = 8'h00;
      bus.start = 1'b1;
      wait_done("slv1");
      wait_done("slv2");
      wait_done("slv3");
      bus.start = 1'b0;
      wait_idle("slv");
      repeat (100) @(negedge clk);
      #1;
      chk("slv done count", done_cnt - dc, 3);
      chk("slv rx count", rx_log.size(), 3);
      if (rx_log.size() >= 3) begin
         chk("slv rx 1", rx_log[0], 8'hFF);
         chk("slv rx 2", rx_log[1], 8'hFE);
         chk("slv rx 3", rx_log[2], 8'hFD);
      end
      chk("slv gap count", gap_log.size(), 3);
      if (gap_log.size() >= 3) begin
         chk("slv gap 1-2", gap_log[1], D + 1);
         chk("slv gap 2-3", gap_log[2], D + 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
